myo_spi_slave: RTL and testbench

MYO_SPI_SLAVE -- requirements
Module: myo_spi_slave

---
 rtl/myo_spi_slave_if.sv | 30 +++
 rtl/myo_spi_slave.sv | 225 ++++++++++++++++++++++
 tb/tb_myo_spi_slave.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/myo_spi_slave_if.sv
`timescale 1ns/1ps
// myo_spi_slave_if: SPI pins from the myocontrol master plus the word-level
// transmit-request / receive-strobe handshake towards the local logic.
interface myo_spi_slave_if;
  logic        sck;
  logic        ss_n;
  logic        mosi;
  logic        miso;
  logic        miso_oe;
  logic        tx_rd;
  logic [3:0]  tx_idx;
  logic [15:0] tx_data;
  logic [15:0] rx_data;
  logic [3:0]  rx_idx;
  logic        rx_valid;
  logic        frame_done;
  logic        frame_err;

  modport slave (
    input  sck, ss_n, mosi, tx_data,
    output miso, miso_oe, tx_rd, tx_idx, rx_data, rx_idx, rx_valid,
           frame_done, frame_err
  );

  modport master (
    output sck, ss_n, mosi, tx_data,
    input  miso, miso_oe, tx_rd, tx_idx, rx_data, rx_idx, rx_valid,
           frame_done, frame_err
  );
endinterface

// File: rtl/myo_spi_slave.sv
`timescale 1ns/1ps
// myo_spi_slave: SPI mode 1 (CPOL=0, CPHA=1), MSB-first slave for fixed-length
// frames of WORDS 16-bit words. sck/ss_n/mosi are oversampled in clk.
//
// state  | meaning
// IDLE   | waiting for a (fresh) ss_n falling edge
// LOAD   | phase 0: tx_rd pulse; phase 1: capture tx_data, drive its MSB
// SHIFT  | shifting a word: tx on sck rise, rx on sck fall
// DONE   | one cycle: frame_done or frame_err is visible
module myo_spi_slave #(
  parameter int WORDS       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  myo_spi_slave_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] LP_WORDS = 4'(WORDS);

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_d;
  logic                   r_ss_d;
  logic [SYNC_STAGES:0]   r_flush;
  logic                   r_armed;

  state_t      r_state;
  logic        r_load_ph;
  logic        r_first;
  logic        r_pend;
  logic [3:0]  r_bit_cnt;
  logic [3:0]  r_word_cnt;
  logic [14:0] r_tx_sr;
  logic [14:0] r_rx_sr;

  logic        r_miso;
  logic        r_miso_oe;
  logic        r_tx_rd;
  logic [3:0]  r_tx_idx;
  logic [15:0] r_rx_data;
  logic [3:0]  r_rx_idx;
  logic        r_rx_valid;
  logic        r_frame_done;
  logic        r_frame_err;

  logic        w_sck_s;
  logic        w_ss_s;
  logic        w_mosi_s;
  logic        w_sck_rise;
  logic        w_sck_fall;
  logic        w_ss_rise;
  logic        w_ss_fall;
  logic        w_start;
  logic        w_frame_ok;
  logic [3:0]  w_wc_next;

  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_ss_s     = r_ss_sync[SYNC_STAGES-1];
  assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck_s & ~r_sck_d;
  assign w_sck_fall = ~w_sck_s & r_sck_d;
  assign w_ss_rise  = w_ss_s & ~r_ss_d;
  assign w_ss_fall  = ~w_ss_s & r_ss_d;
  // A start needs ss_n to have been seen high since reset, so a select that
  // was already low across a reset never opens a frame.
  assign w_start    = r_armed & (w_ss_fall | r_pend);
  assign w_frame_ok = (r_bit_cnt == 4'd0) && (r_word_cnt == LP_WORDS);
  assign w_wc_next  = (r_word_cnt == 4'hF) ? 4'hF : r_word_cnt + 4'd1;

  assign bus.miso       = r_miso;
  assign bus.miso_oe    = r_miso_oe;
  assign bus.tx_rd      = r_tx_rd;
  assign bus.tx_idx     = r_tx_idx;
  assign bus.rx_data    = r_rx_data;
  assign bus.rx_idx     = r_rx_idx;
  assign bus.rx_valid   = r_rx_valid;
  assign bus.frame_done = r_frame_done;
  assign bus.frame_err  = r_frame_err;

  // Synchronize the SPI pins into clk and keep one-cycle-old copies for edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sck_sync  <= '0;
      r_ss_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_d     <= 1'b0;
      r_ss_d      <= 1'b1;
    end else begin
      r_sck_sync[0]  <= bus.sck;
      r_ss_sync[0]   <= bus.ss_n;
      r_mosi_sync[0] <= bus.mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sck_sync[i]  <= r_sck_sync[i-1];
        r_ss_sync[i]   <= r_ss_sync[i-1];
        r_mosi_sync[i] <= r_mosi_sync[i-1];
      end
      r_sck_d <= w_sck_s;
      r_ss_d  <= w_ss_s;
    end
  end

  // Arm frame starts once the synchronizer has flushed and shows ss_n high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flush <= '0;
      r_armed <= 1'b0;
    end else begin
      r_flush <= {r_flush[SYNC_STAGES-1:0], 1'b1};
      r_armed <= r_armed | (r_flush[SYNC_STAGES] & w_ss_s);
    end
  end

  // Frame FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_load_ph    <= 1'b0;
      r_first      <= 1'b0;
      r_pend       <= 1'b0;
      r_bit_cnt    <= 4'd0;
      r_word_cnt   <= 4'd0;
      r_tx_sr      <= '0;
      r_rx_sr      <= '0;
      r_miso       <= 1'b0;
      r_miso_oe    <= 1'b0;
      r_tx_rd      <= 1'b0;
      r_tx_idx     <= 4'd0;
      r_rx_data    <= 16'd0;
      r_rx_idx     <= 4'd0;
      r_rx_valid   <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_ss_rise && (r_state == ST_LOAD || r_state == ST_SHIFT)) begin
        r_state      <= ST_DONE;
        r_frame_done <= w_frame_ok;
        r_frame_err  <= ~w_frame_ok;
        r_miso_oe    <= 1'b0;
        r_miso       <= 1'b0;
        r_tx_rd      <= 1'b0;
        r_pend       <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_pend <= 1'b0;
            if (w_start) begin
              r_state    <= ST_LOAD;
              r_load_ph  <= 1'b0;
              r_bit_cnt  <= 4'd0;
              r_word_cnt <= 4'd0;
              r_tx_rd    <= 1'b1;
              r_tx_idx   <= 4'd0;
              r_miso_oe  <= 1'b1;
              r_miso     <= 1'b0;
            end
          end
          ST_LOAD: begin
            if (!r_load_ph) begin
              r_tx_rd   <= 1'b0;
              r_load_ph <= 1'b1;
            end else begin
              r_load_ph <= 1'b0;
              r_first   <= 1'b1;
              r_state   <= ST_SHIFT;
              // Words past the end of the frame are answered with zeros.
              if (r_word_cnt < LP_WORDS) begin
                r_tx_sr <= bus.tx_data[14:0];
                r_miso  <= bus.tx_data[15];
              end else begin
                r_tx_sr <= '0;
                r_miso  <= 1'b0;
              end
            end
          end
          ST_SHIFT: begin
            if (w_sck_rise) begin
              // The MSB is already on miso from LOAD; the first rise keeps it.
              if (r_first) begin
                r_first <= 1'b0;
              end else begin
                r_miso  <= r_tx_sr[14];
                r_tx_sr <= {r_tx_sr[13:0], 1'b0};
              end
            end else if (w_sck_fall) begin
              r_rx_sr   <= {r_rx_sr[13:0], w_mosi_s};
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd15) begin
                if (r_word_cnt < LP_WORDS) begin
                  r_rx_data  <= {r_rx_sr, w_mosi_s};
                  r_rx_idx   <= r_word_cnt;
                  r_rx_valid <= 1'b1;
                end
                r_word_cnt <= w_wc_next;
                r_load_ph  <= 1'b0;
                r_state    <= ST_LOAD;
                if (w_wc_next < LP_WORDS) begin
                  r_tx_rd  <= 1'b1;
                  r_tx_idx <= w_wc_next;
                end
              end
            end
          end
          ST_DONE: begin
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_state      <= ST_IDLE;
            r_pend       <= w_ss_fall;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_myo_spi_slave.sv
`timescale 1ns/1ps
// Bench for myo_spi_slave: behavioural SPI mode 1 master, tx_data responder
// and an rx scoreboard fed by the master as words are sent.
module tb_myo_spi_slave;
  localparam int WORDS    = 12;
  localparam int SS       = 2;
  localparam int SCK_HALF = 80;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  myo_spi_slave_if bus();

  myo_spi_slave #(.WORDS(WORDS), .SYNC_STAGES(SS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int n_rxv = 0, n_txrd = 0, n_done = 0, n_err = 0, n_oe = 0, n_miso_bad = 0;
  logic [19:0] q_rx[$];
  logic [3:0]  q_txidx[$];

  logic        r_pend_tx = 1'b0;
  logic [15:0] r_tx_val  = 16'h0;

  // tx_data is valid only in the cycle after tx_rd; junk otherwise.
  always @(negedge clk) begin
    bus.tx_data = r_pend_tx ? r_tx_val : 16'hDEAD;
    if (bus.tx_rd) r_tx_val = 16'hA500 + {12'h0, bus.tx_idx};
    r_pend_tx = bus.tx_rd;
  end

  // Monitor: scoreboard pop on rx_valid, event counters.
  always @(negedge clk) begin
    logic [19:0] exp;
    if (bus.rx_valid) begin
      n_rxv++;
      checks++;
      if (q_rx.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected got idx=%0d data=%h required none", bus.rx_idx, bus.rx_data);
      end else begin
        exp = q_rx.pop_front();
        if ({bus.rx_idx, bus.rx_data} !== exp) begin
          errors++;
          $display("FAIL rx_word got idx=%0d data=%h required idx=%0d data=%h",
                   bus.rx_idx, bus.rx_data, exp[19:16], exp[15:0]);
        end
      end
    end
    if (bus.tx_rd) begin
      n_txrd++;
      q_txidx.push_back(bus.tx_idx);
    end
    if (bus.frame_done) n_done++;
    if (bus.frame_err) n_err++;
    if (bus.miso_oe) n_oe++;
    if (!bus.miso_oe && bus.miso !== 1'b0) n_miso_bad++;
  end

  task automatic spi_bits(input logic [15:0] w, input int nbits, output logic [15:0] r);
    r = 16'h0;
    for (int b = 15; b > 15 - nbits; b--) begin
      bus.sck  = 1'b1;
      bus.mosi = w[b];
      #SCK_HALF;
      bus.sck  = 1'b0;
      r[b]     = bus.miso;
      #SCK_HALF;
    end
  endtask

  task automatic run_words(input int first, input int n);
    logic [15:0] w, r, exp_m;
    for (int i = first; i < first + n; i++) begin
      w = 16'h0100 + 16'(i);
      if (i < WORDS) q_rx.push_back({4'(i), w});
      exp_m = (i < WORDS) ? 16'hA500 + 16'(i) : 16'h0000;
      spi_bits(w, 16, r);
      checks++;
      if (r !== exp_m) begin
        errors++;
        $display("FAIL miso_word%0d got %h required %h", i, r, exp_m);
      end
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    logic [29:0] got;
    got = {bus.miso, bus.miso_oe, bus.tx_rd, bus.tx_idx, bus.rx_data, bus.rx_idx,
           bus.rx_valid, bus.frame_done, bus.frame_err};
    checks++;
    if (got !== 30'd0) begin
      errors++;
      $display("FAIL %s got %h required 0", name, got);
    end
  endtask

  task automatic test_reset();
    bus.sck = 1'b0; bus.ss_n = 1'b1; bus.mosi = 1'b0;
    #2 reset_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 check_reset_outputs("reset_outputs");
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_full_frame();
    int d0 = n_done, e0 = n_err, v0 = n_rxv, bad = 0;
    q_txidx.delete();
    bus.ss_n = 1'b0; #SCK_HALF;
    run_words(0, WORDS);
    bus.ss_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_int("full_done", n_done - d0, 1);
    check_int("full_err", n_err - e0, 0);
    check_int("full_rxv", n_rxv - v0, WORDS);
    check_int("full_txrd", q_txidx.size(), WORDS);
    for (int i = 0; i < q_txidx.size(); i++) if (q_txidx[i] !== 4'(i)) bad++;
    check_int("full_txidx_bad", bad, 0);
    #(2*SCK_HALF);
  endtask

  task automatic test_partial_word();
    int d0 = n_done, e0 = n_err, v0 = n_rxv;
    logic [15:0] r;
    bus.ss_n = 1'b0; #SCK_HALF;
    run_words(0, 3);
    spi_bits(16'h0103, 7, r);
    bus.ss_n = 1'b1;
    repeat (SS + 2) @(posedge clk);
    #1 check_int("partial_oe_off", int'(bus.miso_oe), 0);
    repeat (10) @(posedge clk);
    check_int("partial_err", n_err - e0, 1);
    check_int("partial_done", n_done - d0, 0);
    check_int("partial_rxv", n_rxv - v0, 3);
    #(2*SCK_HALF);
  endtask

  task automatic test_overrun();
    int d0 = n_done, e0 = n_err, v0 = n_rxv, t0 = n_txrd;
    bus.ss_n = 1'b0; #SCK_HALF;
    run_words(0, WORDS + 1);
    bus.ss_n = 1'b1;
    repeat (10) @(posedge clk);
    check_int("over_rxv", n_rxv - v0, WORDS);
    check_int("over_txrd", n_txrd - t0, WORDS);
    check_int("over_err", n_err - e0, 1);
    check_int("over_done", n_done - d0, 0);
    #(2*SCK_HALF);
  endtask

  task automatic test_reset_mid_frame();
    int d0, e0, v0, t0, o0;
    logic [15:0] r;
    bus.ss_n = 1'b0; #SCK_HALF;
    run_words(0, 5);
    spi_bits(16'h0105, 4, r);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("midreset_outputs");
    reset_n = 1'b1;
    d0 = n_done; e0 = n_err; v0 = n_rxv; t0 = n_txrd; o0 = n_oe;
    spi_bits(16'h1234, 16, r);
    spi_bits(16'h5678, 16, r);
    repeat (10) @(posedge clk);
    check_int("midreset_rxv", n_rxv - v0, 0);
    check_int("midreset_txrd", n_txrd - t0, 0);
    check_int("midreset_strobes", (n_done - d0) + (n_err - e0), 0);
    check_int("midreset_oe", n_oe - o0, 0);
    bus.ss_n = 1'b1;
    #(4*SCK_HALF);
    d0 = n_done; e0 = n_err;
    bus.ss_n = 1'b0; #SCK_HALF;
    run_words(0, WORDS);
    bus.ss_n = 1'b1;
    repeat (10) @(posedge clk);
    check_int("postreset_done", n_done - d0, 1);
    check_int("postreset_err", n_err - e0, 0);
    #(2*SCK_HALF);
  endtask

  task automatic test_back_to_back();
    int d0 = n_done, e0 = n_err;
    q_txidx.delete();
    bus.ss_n = 1'b0; #SCK_HALF;
    run_words(0, WORDS);
    bus.ss_n = 1'b1;
    #(4*SCK_HALF);
    bus.ss_n = 1'b0; #SCK_HALF;
    run_words(0, WORDS);
    bus.ss_n = 1'b1;
    repeat (10) @(posedge clk);
    check_int("b2b_done", n_done - d0, 2);
    check_int("b2b_err", n_err - e0, 0);
    check_int("b2b_txrd", q_txidx.size(), 2 * WORDS);
    if (q_txidx.size() > WORDS) check_int("b2b_second_idx0", int'(q_txidx[WORDS]), 0);
    #(2*SCK_HALF);
  endtask

  task automatic test_sck_deselected();
    int d0 = n_done, e0 = n_err, v0 = n_rxv, t0 = n_txrd, o0 = n_oe;
    bus.ss_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.sck = 1'b1; bus.mosi = 1'($urandom_range(0, 1)); #SCK_HALF;
      bus.sck = 1'b0; #SCK_HALF;
    end
    repeat (10) @(posedge clk);
    check_int("idle_txrd", n_txrd - t0, 0);
    check_int("idle_rxv", n_rxv - v0, 0);
    check_int("idle_strobes", (n_done - d0) + (n_err - e0), 0);
    check_int("idle_oe", n_oe - o0, 0);
  endtask

  initial begin
    bus.sck = 1'b0; bus.ss_n = 1'b1; bus.mosi = 1'b0;
    test_reset();
    test_full_frame();
    test_partial_word();
    test_overrun();
    test_reset_mid_frame();
    test_back_to_back();
    test_sck_deselected();
    check_int("rx_missing", q_rx.size(), 0);
    check_int("miso_when_oe_low", n_miso_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
